// File: rtl/apb_master_bridge.sv
// APB4 master: CPU-side commands are queued in a FIFO and replayed as SETUP/ACCESS transfers,
// with one response per command (slave error, decode error or ACCESS timeout reported).
module apb_master_bridge #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int NUM_SLV    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [STRB_W-1:0]         cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [STRB_W-1:0]         PSTRB,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t            state_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_push, fifo_pop, fifo_empty;

  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [STRB_W-1:0] head_strb;
  logic [SEL_W-1:0]  head_idx;
  logic              head_dec_err;
  logic [NUM_SLV-1:0] head_onehot;

  logic [DATA_W-1:0] prdata_masked [NUM_SLV];
  logic [DATA_W-1:0] prdata_sel;
  logic              pready_sel, pslverr_sel, to_hit;

  // ---------------- command FIFO ----------------
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = (count_q != FULL_CNT);
  assign fifo_push  = cmd_valid && cmd_ready;
  // A command is launched only when the bus side is free: from IDLE or on the response handshake.
  assign fifo_pop   = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (fifo_push) mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign {head_write, head_addr, head_wdata, head_strb} = mem_q[rd_ptr_q];
  assign head_idx     = head_addr[ADDR_W-1 -: SEL_W];
  assign head_dec_err = (32'(head_idx) >= NUM_SLV);
  assign head_onehot  = NUM_SLV'(1) << head_idx;

  // ---------------- selected-slave return path ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_rdata
      assign prdata_masked[gi] = PRDATA[gi*DATA_W +: DATA_W] & {DATA_W{PSEL[gi]}};
    end
  endgenerate

  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) prdata_sel = prdata_sel | prdata_masked[i];
  end

  assign pready_sel  = |(PREADY & PSEL);
  assign pslverr_sel = |(PSLVERR & PSEL);
  assign to_hit      = (TIMEOUT > 0) && (to_cnt_q == TO_LAST);

  // ---------------- transfer FSM ----------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state_q)
        S_SETUP: begin
          state_q  <= S_ACCESS;
          PENABLE  <= 1'b1;
          to_cnt_q <= '0;
        end
        S_ACCESS: begin
          // PREADY in the last allowed cycle takes priority over the timeout abort.
          if (pready_sel) begin
            state_q     <= S_RESP;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : prdata_sel;
            rsp_err     <= pslverr_sel;
            rsp_timeout <= 1'b0;
          end else if (to_hit) begin
            state_q     <= S_RESP;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: ;
      endcase

      // Launch overrides the case above (shared by IDLE and the RESP handshake).
      if (fifo_pop) begin
        to_cnt_q <= '0;
        if (head_dec_err) begin
          state_q     <= S_RESP;
          PSEL        <= '0;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b0;
        end else begin
          state_q <= S_SETUP;
          PSEL    <= head_onehot;
          PWRITE  <= head_write;
          PADDR   <= head_addr;
          PWDATA  <= head_wdata;
          PSTRB   <= head_write ? head_strb : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: stimulus queues expected responses and APB transfers,
// negedge monitors pop and compare; a small per-slave model supplies PREADY/PRDATA/PSLVERR.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [0:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [8:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [0:0]  PSTRB;
  logic [1:0]  PREADY = '0;
  logic [15:0] PRDATA = '0;
  logic [1:0]  PSLVERR = '0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .FIFO_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct { logic [7:0] rdata; logic err; logic to; } rsp_t;
  typedef struct { logic [1:0] sel; logic [8:0] addr; logic wr; logic [7:0] wdata; logic strb; int en; } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- slave model ----------------
  int         wait_cfg [2] = '{0, 0};
  logic       stuck    [2] = '{1'b0, 1'b0};
  logic       err_cfg  [2] = '{1'b0, 1'b0};
  logic [7:0] rd_cfg   [2] = '{8'h81, 8'h3C};
  int         acc      [2] = '{0, 0};

  always @(negedge PCLK) begin
    for (int s = 0; s < 2; s++) begin
      if (PSEL[s] && PENABLE) begin
        PREADY[s] = !stuck[s] && (acc[s] >= wait_cfg[s]);
        acc[s]++;
      end else begin
        PREADY[s] = 1'b0;
        acc[s]    = 0;
      end
      PSLVERR[s]       = err_cfg[s];
      PRDATA[s*8 +: 8] = rd_cfg[s];
    end
  end

  // ---------------- response monitor ----------------
  int rsp_n = 0;
  always @(negedge PCLK) begin
    rsp_t e;
    if (!PRESET && rsp_valid && rsp_ready) begin
      rsp_n++;
      $display("rsp %0d: rdata=0x%02h err=%0b timeout=%0b", rsp_n, rsp_rdata, rsp_err, rsp_timeout);
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got a response, required none");
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  // ---------------- APB monitor ----------------
  logic       in_x = 1'b0;
  logic [1:0] c_sel;
  logic [8:0] c_addr;
  logic       c_wr;
  logic [7:0] c_wd;
  logic       c_strb;
  logic       c_bad;
  int         c_en, c_len;

  always @(negedge PCLK) begin
    apb_t e;
    if (PRESET) begin
      in_x = 1'b0;
    end else if (PSEL != 2'b00) begin
      if (!in_x) begin
        in_x   = 1'b1;
        c_sel  = PSEL;
        c_addr = PADDR;
        c_wr   = PWRITE;
        c_wd   = PWDATA;
        c_strb = PSTRB[0];
        c_bad  = PENABLE;
        c_en   = 0;
        c_len  = 1;
      end else begin
        c_len++;
        if (PENABLE) c_en++;
        if (PSEL != c_sel || PADDR != c_addr || PWRITE != c_wr || PWDATA != c_wd || PSTRB[0] != c_strb)
          c_bad = 1'b1;
      end
    end else if (in_x) begin
      in_x = 1'b0;
      $display("apb: psel=%b addr=0x%03h write=%0b wdata=0x%02h strb=%0b enable_cycles=%0d",
               c_sel, c_addr, c_wr, c_wd, c_strb, c_en);
      if (apb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL apb_unexpected: got a transfer to 0x%0h, required none", c_addr);
      end else begin
        e = apb_q.pop_front();
        chk("apb_psel", 32'(c_sel), 32'(e.sel));
        chk("apb_paddr", 32'(c_addr), 32'(e.addr));
        chk("apb_pwrite", 32'(c_wr), 32'(e.wr));
        chk("apb_pwdata", 32'(c_wd), 32'(e.wdata));
        chk("apb_pstrb", 32'(c_strb), 32'(e.strb));
        chk("apb_penable_cycles", 32'(c_en), 32'(e.en));
        chk("apb_psel_cycles", 32'(c_len), 32'(e.en + 1));
        chk("apb_phase_stable", 32'(c_bad), 32'(0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic wr, input logic [8:0] addr, input logic [7:0] wd, input logic strb,
                      input int en, input logic [7:0] ex_rd, input logic ex_err, input logic ex_to);
    apb_t a;
    rsp_t r;
    int   guard;
    a.sel   = 2'b01 << addr[8];
    a.addr  = addr;
    a.wr    = wr;
    a.wdata = wd;
    a.strb  = wr ? strb : 1'b0;
    a.en    = en;
    r.rdata = ex_rd;
    r.err   = ex_err;
    r.to    = ex_to;
    @(negedge PCLK);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_wdata   = wd;
    cmd_strb[0] = strb;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", guard);
      cmd_valid = 1'b0;
    end else begin
      apb_q.push_back(a);
      rsp_q.push_back(r);
      $display("cmd: write=%0b addr=0x%03h wdata=0x%02h strb=%0b", wr, addr, wd, strb);
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge PCLK);
      g++;
    end while ((rsp_q.size() != 0 || apb_q.size() != 0 || PSEL != 2'b00 || rsp_valid) && g < 400);
    if (rsp_q.size() != 0 || apb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: %0d responses and %0d transfers outstanding, required 0",
               rsp_q.size(), apb_q.size());
      rsp_q.delete();
      apb_q.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   n;
    logic seen;

    repeat (3) @(negedge PCLK);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_psel", 32'(PSEL), 32'(0));
    chk("reset_penable", 32'(PENABLE), 32'(0));
    chk("reset_paddr", 32'(PADDR), 32'(0));
    chk("reset_rsp_err", 32'(rsp_err), 32'(0));
    PRESET = 1'b0;

    // Zero-wait write, with handshake-to-response latency.
    send(1'b1, 9'h005, 8'hA5, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!rsp_valid && n < 20);
    chk("latency_negedges_to_rsp", 32'(n), 32'(4));
    wait_idle();

    // Read from slave 1 with 3 wait states.
    wait_cfg[1] = 3;
    send(1'b0, 9'h105, 8'h00, 1'b1, 4, 8'h3C, 1'b0, 1'b0);
    wait_idle();
    wait_cfg[1] = 0;

    // Timeout on slave 0, queued command to slave 1 still completes.
    stuck[0] = 1'b1;
    send(1'b0, 9'h010, 8'h00, 1'b0, 16, 8'h00, 1'b1, 1'b1);
    send(1'b1, 9'h111, 8'h5A, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    wait_idle();
    stuck[0] = 1'b0;

    // Slave error on a read: data still returned.
    err_cfg[1] = 1'b1;
    wait_cfg[1] = 1;
    rd_cfg[1] = 8'h77;
    send(1'b0, 9'h1F0, 8'h00, 1'b0, 2, 8'h77, 1'b1, 1'b0);
    wait_idle();
    err_cfg[1] = 1'b0;
    wait_cfg[1] = 0;
    rd_cfg[1] = 8'h3C;

    // Back-pressure: 5 commands fill 4 FIFO entries plus one in flight.
    rsp_ready = 1'b0;
    send(1'b1, 9'h001, 8'h11, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    send(1'b0, 9'h102, 8'h00, 1'b0, 1, 8'h3C, 1'b0, 1'b0);
    send(1'b1, 9'h103, 8'h22, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    send(1'b0, 9'h004, 8'h00, 1'b0, 1, 8'h81, 1'b0, 1'b0);
    send(1'b1, 9'h006, 8'h33, 1'b0, 1, 8'h00, 1'b0, 1'b0);
    @(negedge PCLK);
    chk("full_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("full_rsp_held", 32'(rsp_valid), 32'(1));
    repeat (3) @(negedge PCLK);
    chk("full_no_new_psel", 32'(PSEL), 32'(0));
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during ACCESS with a second command queued.
    stuck[0] = 1'b1;
    send(1'b0, 9'h020, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    send(1'b1, 9'h030, 8'h44, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!PENABLE && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("mid_reset_in_access", 32'(PENABLE), 32'(1));
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mid_reset_psel", 32'(PSEL), 32'(0));
    chk("mid_reset_penable", 32'(PENABLE), 32'(0));
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'(1));
    rsp_q.delete();
    apb_q.delete();
    @(negedge PCLK);
    PRESET = 1'b0;
    stuck[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (PSEL != 2'b00 || rsp_valid) seen = 1'b1;
    end
    chk("mid_reset_fifo_flushed", 32'(seen), 32'(0));
    send(1'b1, 9'h0AA, 8'hC3, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
